// File: rtl/femto_spi_pkg.sv
// Shared types and constants for the shared-SPI-bus arbiter.
package femto_spi_pkg;
  typedef enum logic [1:0] {IDLE, OWN_F, OWN_R, GUARD} arb_state_e;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FLASH = 2'd1;
  localparam logic [1:0] OWN_RAM   = 2'd2;

  localparam int GUARD_W = 4;
endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Controller-side handshakes and top-level SPI pins of the shared bus.
interface spi_bus_arbiter_if;
  logic       req_f, gnt_f, f_clk, f_mosi, f_cs_n, f_miso;
  logic       req_r, gnt_r, r_clk, r_mosi, r_cs_n, r_miso;
  logic       spi_clk, spi_mosi, spi_miso, spi_cs_n_flash, spi_cs_n_ram;
  logic [1:0] owner;
  logic       err;

  modport slave (
    input  req_f, f_clk, f_mosi, f_cs_n, req_r, r_clk, r_mosi, r_cs_n, spi_miso,
    output gnt_f, f_miso, gnt_r, r_miso, spi_clk, spi_mosi, spi_cs_n_flash,
           spi_cs_n_ram, owner, err
  );

  modport master (
    output req_f, f_clk, f_mosi, f_cs_n, req_r, r_clk, r_mosi, r_cs_n, spi_miso,
    input  gnt_f, f_miso, gnt_r, r_miso, spi_clk, spi_mosi, spi_cs_n_flash,
           spi_cs_n_ram, owner, err
  );
endinterface

// File: rtl/spi_guard_timer.sv
// Loadable down-counter; done is high for the single cycle the count sits at 1.
module spi_guard_timer
  import femto_spi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [GUARD_W-1:0] load_val,
  output logic               done
);
  logic [GUARD_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset)
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;

  assign done = (cnt == GUARD_W'(1));
endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter for one shared SPI bus (flash + RAM controllers),
// with a CS-high guard gap between owners and a sticky protocol-error flag.
module spi_bus_arbiter
  import femto_spi_pkg::*;
#(
  parameter int PRIORITY     = 0,  // 0 round-robin, 1 flash wins ties
  parameter int GUARD_CYCLES = 2   // 1..15
)(
  input  logic             clk,
  input  logic             reset,
  spi_bus_arbiter_if.slave bus
);
  arb_state_e state, state_nxt;
  logic       gnt_f_q, gnt_r_q;
  logic       last_f;   // 1: flash held the bus last
  logic       err_q;
  logic       load, done, drop_err, viol;

  spi_guard_timer u_guard (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (GUARD_W'(GUARD_CYCLES)),
    .done     (done)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop_err  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_f && bus.req_r)
          state_nxt = (PRIORITY != 0 || !last_f) ? OWN_F : OWN_R;
        else if (bus.req_f) state_nxt = OWN_F;
        else if (bus.req_r) state_nxt = OWN_R;
      end
      OWN_F: if (!bus.req_f) begin
        state_nxt = GUARD;
        load      = 1'b1;
        drop_err  = !bus.f_cs_n;
      end
      OWN_R: if (!bus.req_r) begin
        state_nxt = GUARD;
        load      = 1'b1;
        drop_err  = !bus.r_cs_n;
      end
      GUARD: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    viol = drop_err
         | (!bus.f_cs_n && state != OWN_F)
         | (!bus.r_cs_n && state != OWN_R);
  end

  // Grants are kept as their own flops so the MISO return path is one AND.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      gnt_f_q <= 1'b0;
      gnt_r_q <= 1'b0;
      last_f  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_f_q <= (state_nxt == OWN_F);
      gnt_r_q <= (state_nxt == OWN_R);
      if (state == OWN_F && state_nxt == GUARD) last_f <= 1'b1;
      if (state == OWN_R && state_nxt == GUARD) last_f <= 1'b0;
      err_q   <= err_q | viol;
    end

  assign bus.gnt_f          = gnt_f_q;
  assign bus.gnt_r          = gnt_r_q;
  assign bus.owner          = gnt_f_q ? OWN_FLASH : (gnt_r_q ? OWN_RAM : OWN_NONE);
  assign bus.err            = err_q;
  assign bus.spi_clk        = (gnt_f_q & bus.f_clk)  | (gnt_r_q & bus.r_clk);
  assign bus.spi_mosi       = (gnt_f_q & bus.f_mosi) | (gnt_r_q & bus.r_mosi);
  assign bus.spi_cs_n_flash = ~gnt_f_q | bus.f_cs_n;
  assign bus.spi_cs_n_ram   = ~gnt_r_q | bus.r_cs_n;
  assign bus.f_miso         = bus.spi_miso & gnt_f_q;
  assign bus.r_miso         = bus.spi_miso & gnt_r_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: round-robin (inst 0) and fixed-priority (inst 1)
// copies driven by reactive controller tasks, scored against a cycle model.
module tb_spi_bus_arbiter;
  localparam int GUARD = 2;

  typedef struct {int hold; logic merr;} exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [2][2], cs [2][2], sclk [2][2], mosi [2][2], miso [2];
  logic       gnt_o [2][2], csp [2][2], err_o [2];
  logic [1:0] own_o [2];
  string      glog [2];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [1:0] a, input logic [1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    spi_bus_arbiter_if bus();
    spi_bus_arbiter #(.PRIORITY(g), .GUARD_CYCLES(GUARD)) dut (
      .clk(clk), .reset(rst), .bus(bus));

    assign bus.req_f    = req[g][0];
    assign bus.f_clk    = sclk[g][0];
    assign bus.f_mosi   = mosi[g][0];
    assign bus.f_cs_n   = cs[g][0];
    assign bus.req_r    = req[g][1];
    assign bus.r_clk    = sclk[g][1];
    assign bus.r_mosi   = mosi[g][1];
    assign bus.r_cs_n   = cs[g][1];
    assign bus.spi_miso = miso[g];
    assign gnt_o[g][0]  = bus.gnt_f;
    assign gnt_o[g][1]  = bus.gnt_r;
    assign csp[g][0]    = bus.spi_cs_n_flash;
    assign csp[g][1]    = bus.spi_cs_n_ram;
    assign own_o[g]     = bus.owner;
    assign err_o[g]     = bus.err;

    // Reference: who holds the bus, guard cycles left, who held it last.
    int   hold = 0, gap = 0, last = 2;
    logic merr = 1'b0;
    exp_t q [$];

    initial forever begin
      @(posedge clk);
      if (rst) begin
        hold = 0; gap = 0; last = 2; merr = 1'b0;
      end else begin
        if ((cs[g][0] == 1'b0 && hold != 1) || (cs[g][1] == 1'b0 && hold != 2))
          merr = 1'b1;
        if (hold != 0) begin
          if (!req[g][hold-1]) begin
            if (cs[g][hold-1] == 1'b0) merr = 1'b1;
            last = hold; hold = 0; gap = GUARD;
          end
        end else if (gap > 0) gap--;
        else if (req[g][0] && req[g][1]) hold = (g == 1) ? 1 : ((last == 1) ? 2 : 1);
        else if (req[g][0]) hold = 1;
        else if (req[g][1]) hold = 2;
      end
      q.push_back('{hold, merr});
    end

    logic pf = 1'b0, pr = 1'b0;
    initial forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (rst) e = '{0, 1'b0};
        chk($sformatf("i%0d owner", g),    bus.owner, 2'(e.hold));
        chk($sformatf("i%0d gnt_f", g),    {1'b0, bus.gnt_f}, {1'b0, e.hold == 1});
        chk($sformatf("i%0d gnt_r", g),    {1'b0, bus.gnt_r}, {1'b0, e.hold == 2});
        chk($sformatf("i%0d err", g),      {1'b0, bus.err}, {1'b0, e.merr});
        chk($sformatf("i%0d cs_flash", g), {1'b0, bus.spi_cs_n_flash},
            {1'b0, (e.hold == 1) ? cs[g][0] : 1'b1});
        chk($sformatf("i%0d cs_ram", g),   {1'b0, bus.spi_cs_n_ram},
            {1'b0, (e.hold == 2) ? cs[g][1] : 1'b1});
        chk($sformatf("i%0d spi_clk", g),  {1'b0, bus.spi_clk},
            {1'b0, (e.hold == 0) ? 1'b0 : sclk[g][e.hold-1]});
        chk($sformatf("i%0d spi_mosi", g), {1'b0, bus.spi_mosi},
            {1'b0, (e.hold == 0) ? 1'b0 : mosi[g][e.hold-1]});
        chk($sformatf("i%0d f_miso", g),   {1'b0, bus.f_miso}, {1'b0, (e.hold == 1) & miso[g]});
        chk($sformatf("i%0d r_miso", g),   {1'b0, bus.r_miso}, {1'b0, (e.hold == 2) & miso[g]});
      end
      if (bus.gnt_f && !pf) glog[g] = {glog[g], "F"};
      if (bus.gnt_r && !pr) glog[g] = {glog[g], "R"};
      pf = bus.gnt_f;
      pr = bus.gnt_r;
    end
  end

  // Well-behaved controller: request, wait for grant, run a burst, raise CS,
  // then drop req. With bad=1 req is dropped while CS is still low.
  task automatic xact(input int i, input int s, input int len, input bit bad);
    int n = 0;
    req[i][s] = 1'b1;
    while (gnt_o[i][s] !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("i%0d s%0d grant", i, s), {1'b0, gnt_o[i][s]}, 2'd1);
    if (gnt_o[i][s] !== 1'b1) req[i][s] = 1'b0;
    else begin
      cs[i][s] = 1'b0;
      repeat (len) begin
        @(posedge clk); #1;
        sclk[i][s] = 1'($urandom);
        mosi[i][s] = 1'($urandom);
      end
      sclk[i][s] = 1'b0;
      mosi[i][s] = 1'b0;
      if (!bad) begin
        cs[i][s] = 1'b1;
        @(posedge clk); #1;
        req[i][s] = 1'b0;
        @(posedge clk); #1;
      end else begin
        req[i][s] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("i%0d drop err", i), {1'b0, err_o[i]}, 2'd1);
        chk($sformatf("i%0d drop cs pin", i), {1'b0, csp[i][s]}, 2'd1);
        cs[i][s] = 1'b1;
      end
    end
  endtask

  // RAM pulls its CS low while flash owns the bus.
  task automatic intrude(input int i);
    repeat (6) @(posedge clk);
    #1 cs[i][1] = 1'b0;
    @(negedge clk);
    chk($sformatf("i%0d intrude cs_ram", i), {1'b0, csp[i][1]}, 2'd1);
    @(posedge clk); #1;
    chk($sformatf("i%0d intrude err", i), {1'b0, err_o[i]}, 2'd1);
    cs[i][1] = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk); #1;
    miso[0] = 1'($urandom);
    miso[1] = 1'($urandom);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      miso[i] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        req[i][s] = 1'b1; cs[i][s] = 1'b1; sclk[i][s] = 1'b0; mosi[i][s] = 1'b0;
      end
    end

    // Reset with both requesting, then flash gets the first grant.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d rst gnt", i), {gnt_o[i][0], gnt_o[i][1]}, 2'd0);
      chk($sformatf("i%0d rst cs", i), {csp[i][0], csp[i][1]}, 2'd3);
      chk($sformatf("i%0d rst owner", i), own_o[i], 2'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d first gnt_f", i), {1'b0, gnt_o[i][0]}, 2'd1);
      req[i][0] = 1'b0; req[i][1] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;

    // Flash alone, long burst.
    fork
      xact(0, 0, 40, 1'b0);
      xact(1, 0, 40, 1'b0);
    join
    repeat (4) @(posedge clk);
    #1;

    // Contention: both keep re-requesting.
    glog[0] = "";
    glog[1] = "";
    fork
      repeat (4) xact(0, 0, 10, 1'b0);
      repeat (4) xact(0, 1, 10, 1'b0);
      repeat (4) xact(1, 0, 10, 1'b0);
      repeat (4) xact(1, 1, 10, 1'b0);
    join
    repeat (4) @(posedge clk);
    checks++;
    if (glog[0] != "RFRFRFRF") begin
      errors++;
      $display("FAIL rr order got %s want RFRFRFRF", glog[0]);
    end
    checks++;
    if (glog[1] != "FFFFRRRR") begin
      errors++;
      $display("FAIL fixed order got %s want FFFFRRRR", glog[1]);
    end

    // Owner drops req with CS still low.
    pulse_reset();
    fork
      xact(0, 0, 8, 1'b1);
      xact(1, 0, 8, 1'b1);
    join
    repeat (4) @(posedge clk);

    // Non-owner drives CS low; err is sticky afterwards.
    pulse_reset();
    fork
      xact(0, 0, 20, 1'b0);
      xact(1, 0, 20, 1'b0);
      intrude(0);
      intrude(1);
    join
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("i%0d err sticky", i), {1'b0, err_o[i]}, 2'd1);

    // Reset in the middle of a RAM transfer.
    pulse_reset();
    req[0][1] = 1'b1; req[1][1] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d ram gnt", i), {1'b0, gnt_o[i][1]}, 2'd1);
      cs[i][1] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d async gnt_r", i), {1'b0, gnt_o[i][1]}, 2'd0);
      chk($sformatf("i%0d async cs_ram", i), {1'b0, csp[i][1]}, 2'd1);
      cs[i][1] = 1'b1; req[i][1] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("i%0d post-reset owner", i), own_o[i], 2'd0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
